// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
// Shares one Avalon-MM master port between the instruction-fetch requester and the
// load/store requester. One transaction at a time: IDLE (grant + latch), ISSUE (drive the
// bus, absorb waitrequest), RESP (one-cycle done pulse, read data returned).
// Ties are broken round-robin against the previous grant.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch_req/fetch_addr           -> fetch_done/fetch_rdata
//   data_req/data_we/data_addr/data_wdata/data_byteenable -> data_done/data_rdata
//   busy                           high whenever not idle
//   address/read/write/writedata/byteenable/waitrequest/readdata  Avalon master side
module mips_cpu_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteenable,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_data_q, grant_data_d;  // owner of the current transaction, 1 = data
  logic        last_data_q, last_data_d;    // winner of the previous grant, 1 = data
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;              // word address; byte offset is always dropped
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] fetch_hold_q, fetch_hold_d;
  logic [31:0] data_hold_q, data_hold_d;
  logic        pick_data;

  // On a tie the requester that lost last time wins.
  always_comb begin
    if (fetch_req && data_req) begin
      pick_data = ~last_data_q;
    end else begin
      pick_data = data_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_data_d = grant_data_q;
    last_data_d  = last_data_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    fetch_hold_d = fetch_hold_q;
    data_hold_d  = data_hold_q;
    fetch_done   = 1'b0;
    data_done    = 1'b0;
    fetch_rdata  = fetch_hold_q;
    data_rdata   = data_hold_q;
    address      = '0;
    read         = 1'b0;
    write        = 1'b0;
    writedata    = '0;
    byteenable   = '0;

    unique case (state_q)
      StIdle: begin
        if (fetch_req || data_req) begin
          state_d      = StIssue;
          grant_data_d = pick_data;
          last_data_d  = pick_data;
          if (pick_data) begin
            we_d    = data_we;
            addr_d  = data_addr[31:2];
            wdata_d = data_wdata;
            be_d    = data_byteenable;
          end else begin
            we_d    = 1'b0;
            addr_d  = fetch_addr[31:2];
            wdata_d = '0;
            be_d    = 4'hF;
          end
        end
      end
      StIssue: begin
        address    = {addr_q, 2'b00};
        read       = ~we_q;
        write      = we_q;
        writedata  = we_q ? wdata_q : '0;
        byteenable = be_q;
        if (!waitrequest) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d    = StIdle;
        fetch_done = ~grant_data_q;
        data_done  = grant_data_q;
        // Read data goes straight through this cycle and is kept for later cycles.
        if (!we_q) begin
          if (grant_data_q) begin
            data_rdata  = readdata;
            data_hold_d = readdata;
          end else begin
            fetch_rdata  = readdata;
            fetch_hold_d = readdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b1;  // fetch wins the first tie
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      fetch_hold_q <= '0;
      data_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_data_q <= grant_data_d;
      last_data_q  <= last_data_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      fetch_hold_q <= fetch_hold_d;
      data_hold_q  <= data_hold_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: directed scenarios followed by randomized rounds.
// The driver predicts each transaction (grant order, bus fields, read data from a
// reference memory) and queues it; a negedge monitor checks the bus and completions.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_done;
  logic [31:0] fetch_rdata;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [3:0]  data_byteenable = '0;
  logic        data_done;
  logic [31:0] data_rdata;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = '0;

  mips_cpu_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_byteenable(data_byteenable),
    .data_done(data_done), .data_rdata(data_rdata),
    .busy(busy), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] slave_mem[logic [29:0]];
  logic [31:0] exp_fetch_hold = '0;
  logic [31:0] exp_data_hold = '0;
  bit          last_data = 1'b1;
  int          wait_mode = 0;  // 0 random stalls, 1 none, 2 forever, 3 exactly three

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Fixed memory contents seen before any store.
  function automatic logic [31:0] mem_init(input logic [29:0] w);
    if (w == 30'h2FF0_0000) return 32'h2402_000A;
    if (w == 30'h0000_0800) return 32'h0000_FFFF;
    return {w, 2'b01} ^ 32'hA5C3_96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  function automatic logic [31:0] slave_rd(input logic [29:0] w);
    return slave_mem.exists(w) ? slave_mem[w] : mem_init(w);
  endfunction

  function automatic void push_fetch(input logic [31:0] a);
    txn_t t;
    t.is_data = 1'b0; t.we = 1'b0; t.addr = {a[31:2], 2'b00};
    t.wdata = '0; t.be = 4'hF; t.rdata = ref_rd(a[31:2]);
    exp_q.push_back(t);
  endfunction

  function automatic void push_data(input logic we, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [3:0] be);
    txn_t t;
    t.is_data = 1'b1; t.we = we; t.addr = {a[31:2], 2'b00};
    t.wdata = wd; t.be = be; t.rdata = we ? '0 : ref_rd(a[31:2]);
    if (we) ref_mem[a[31:2]] = merge(ref_rd(a[31:2]), wd, be);
    exp_q.push_back(t);
  endfunction

  // Avalon slave: stalls per wait_mode, returns read data the cycle after acceptance.
  logic        slv_acc, slv_rd;
  logic [29:0] slv_w;
  int          issue_cnt = 0;
  always @(posedge clk) begin
    slv_acc = reset && (read || write) && !waitrequest;
    slv_rd  = slv_acc && read;
    slv_w   = address[31:2];
    if (slv_acc && write) slave_mem[slv_w] = merge(slave_rd(slv_w), writedata, byteenable);
    if (!(read || write) || slv_acc) issue_cnt = 0;
    else issue_cnt++;
    #1;
    readdata = slv_rd ? slave_rd(slv_w) : $urandom;
    if (read || write) begin
      case (wait_mode)
        1:       waitrequest = 1'b0;
        2:       waitrequest = 1'b1;
        3:       waitrequest = (issue_cnt < 3);
        default: waitrequest = ($urandom_range(0, 2) == 0);
      endcase
    end else begin
      waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: bus fields during ISSUE, grant and read data at completion, holds otherwise.
  txn_t        mon_t;
  logic [31:0] mon_wd;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_fetch_hold = '0;
      exp_data_hold  = '0;
    end else begin
      if (read || write) begin
        if (exp_q.size() == 0) begin
          check("bus_unexpected", {read, write}, 2'b00);
        end else begin
          mon_t  = exp_q[0];
          mon_wd = (mon_t.is_data && !mon_t.we) ? 32'h0 : writedata;
          check("bus", {read, write, address, byteenable, mon_wd},
                {~mon_t.we, mon_t.we, mon_t.addr, mon_t.be,
                 (mon_t.is_data && !mon_t.we) ? 32'h0 : mon_t.wdata});
        end
      end
      if (fetch_done || data_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {fetch_done, data_done}, 2'b00);
        end else begin
          mon_t = exp_q.pop_front();
          check("grant", {fetch_done, data_done}, {~mon_t.is_data, mon_t.is_data});
          if (mon_t.we) begin
            check("rdata", {fetch_rdata, data_rdata}, {exp_fetch_hold, exp_data_hold});
          end else if (mon_t.is_data) begin
            check("rdata", {fetch_rdata, data_rdata}, {exp_fetch_hold, mon_t.rdata});
            exp_data_hold = mon_t.rdata;
          end else begin
            check("rdata", {fetch_rdata, data_rdata}, {mon_t.rdata, exp_data_hold});
            exp_fetch_hold = mon_t.rdata;
          end
        end
      end else begin
        check("hold", {fetch_rdata, data_rdata}, {exp_fetch_hold, exp_data_hold});
      end
    end
  end

  // One round: raise the chosen requests together in IDLE, drop each on its done.
  task automatic run_round(input bit do_f, input bit do_d, input logic [31:0] fa,
                           input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                           input logic [3:0] dbe, input int lat_f, input int lat_d);
    bit pend_f, pend_d;
    int cyc;
    if (do_f && do_d) begin
      if (last_data) begin
        push_fetch(fa); push_data(dwe, da, dwd, dbe); last_data = 1'b1;
      end else begin
        push_data(dwe, da, dwd, dbe); push_fetch(fa); last_data = 1'b0;
      end
    end else if (do_f) begin
      push_fetch(fa); last_data = 1'b0;
    end else if (do_d) begin
      push_data(dwe, da, dwd, dbe); last_data = 1'b1;
    end
    @(posedge clk); #1;
    fetch_req = do_f; fetch_addr = fa;
    data_req = do_d; data_we = dwe; data_addr = da; data_wdata = dwd; data_byteenable = dbe;
    pend_f = do_f; pend_d = do_d; cyc = 0;
    while ((pend_f || pend_d) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (pend_f && fetch_done) begin
        pend_f = 1'b0; fetch_req = 1'b0;
        if (lat_f >= 0) check("lat_fetch", cyc, lat_f);
      end
      if (pend_d && data_done) begin
        pend_d = 1'b0; data_req = 1'b0;
        if (lat_d >= 0) check("lat_data", cyc, lat_d);
      end
      // Once latched, the requester's fields must no longer matter.
      if (!do_f && pend_d) begin
        data_we = 1'($urandom_range(0, 1)); data_addr = $urandom;
        data_wdata = $urandom; data_byteenable = 4'($urandom_range(0, 15));
      end
      if (!do_d && pend_f) fetch_addr = $urandom;
    end
    if (pend_f || pend_d) begin
      check("timeout", {pend_f, pend_d}, 2'b00);
      fetch_req = 1'b0; data_req = 1'b0;
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("reset_outputs",
          {fetch_done, data_done, busy, read, write, address, writedata, byteenable,
           fetch_rdata, data_rdata}, '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    // Single fetch from the boot vector, then the instruction must stay held.
    wait_mode = 1;
    run_round(1'b1, 1'b0, 32'hBFC0_0000, 1'b0, '0, '0, '0, 2, -1);
    repeat (3) @(posedge clk);
    #1 check("fetch_hold_c5", fetch_rdata, 32'h2402_000A);

    // Store stalled for three cycles.
    wait_mode = 3;
    run_round(1'b0, 1'b1, '0, 1'b1, 32'h0000_1007, 32'hDEAD_BEEF, 4'b0011, -1, 5);

    // Reset while a read is stalled: everything drops at once, nothing completes.
    wait_mode = 2;
    push_fetch(32'h0000_1010);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h0000_1010;
    repeat (2) @(posedge clk);
    #2 check("stalled_read", {read, busy}, 2'b11);
    #1 reset = 1'b0;
    #1 check("async_reset", {read, busy, fetch_done, data_done}, 4'b0000);
    fetch_req = 1'b0;
    last_data = 1'b1;
    @(negedge clk);
    #1 reset = 1'b1;

    // Tie after reset goes to fetch, then round-robin.
    wait_mode = 1;
    run_round(1'b1, 1'b1, 32'h0000_1020, 1'b0, 32'h0000_1030, '0, 4'hF, 2, 5);
    run_round(1'b1, 1'b1, 32'h0000_1040, 1'b1, 32'h0000_1044, 32'h1234_5678, 4'hF, 2, 5);
    run_round(1'b1, 1'b1, 32'h0000_1044, 1'b0, 32'h0000_1040, '0, 4'hF, 2, 5);

    // Partial-lane load; fetch hold must not move.
    run_round(1'b0, 1'b1, '0, 1'b0, 32'h0000_2000, '0, 4'b1100, -1, 2);

    // Randomized rounds with random stalls, lanes and directions.
    wait_mode = 0;
    for (int r = 0; r < 200; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_round(sel[0], sel[1], 32'h1000 + $urandom_range(0, 255),
                1'($urandom_range(0, 1)), 32'h1000 + $urandom_range(0, 255), $urandom,
                4'($urandom_range(0, 15)), -1, -1);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
# mips_cpu_bus_arbiter

Shares the single Avalon memory-mapped master port of `mips_cpu_bus` between the instruction-fetch requester and the load/store (data) requester. Each requester presents a level request with a latched address/data, and the arbiter sequences one Avalon transaction at a time, absorbing `waitrequest` stalls. It returns a one-cycle completion pulse with read data. When both requesters are pending, arbitration is round-robin. The block sits between the CPU state machine and the top-level Avalon ports.

## Interface
- No parameters; widths are fixed at 32-bit address/data, 4-bit byteenable.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  fetch request; held high until `fetch_done`.
- `fetch_addr`  in  32  fetch word address; stable while `fetch_req` is high.
- `fetch_done`  out  1  one-cycle pulse; the fetch has completed.
- `fetch_rdata`  out  32  instruction word; valid when `fetch_done` is high, then held.
- `data_req`  in  1  load/store request; held high until `data_done`.
- `data_we`  in  1  1 = write, 0 = read.
- `data_addr`  in  32  data address.
- `data_wdata`  in  32  store data.
- `data_byteenable`  in  4  byte lanes for the load/store.
- `data_done`  out  1  one-cycle completion pulse.
- `data_rdata`  out  32  load data; valid when `data_done` is high, then held.
- `busy`  out  1  high in any state other than IDLE.
- `address`  out  32  Avalon address.
- `read`  out  1  Avalon read request.
- `write`  out  1  Avalon write request.
- `waitrequest`  in  1  Avalon stall.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte enables.
- `readdata`  in  32  Avalon read data; valid in the cycle after an accepted read.

## Operation
- **States:** IDLE, ISSUE, RESP.
- **IDLE:**
  - Avalon outputs are all 0.
  - If any request is high, grant one requester and latch its address, write data, byteenable and direction into internal registers. Then go to ISSUE.
  - If only one request is high, it wins.
  - If both are high, the requester not granted last time wins.
  - `last_grant` is updated on each grant.
- **ISSUE:**
  - Drive `address` = latched address with bits [1:0] forced to 00.
  - Fetch: `read`=1, `byteenable`=1111, `writedata`=0.
  - Data read: `read`=1, `byteenable`=latched `data_byteenable`.
  - Data write: `write`=1, `writedata`=latched `data_wdata`, `byteenable` as latched.
  - Stay in ISSUE with outputs unchanged while `waitrequest`=1. When `waitrequest`=0, go to RESP.
- **RESP:**
  - `read`/`write`=0.
  - The granted requester's `*_done` is 1 for exactly this cycle.
  - For a read, `*_rdata` = `readdata` combinationally. `readdata` is also captured into that requester's hold register, so `*_rdata` holds its value afterward until that requester's next read RESP.
  - For a write, `*_rdata` is unchanged.
  - Next state is IDLE.
- **Request sampling:** requests are sampled only in IDLE. A requester must deassert `*_req` the cycle after `*_done`. A `*_req` still high in IDLE is treated as a new request.
- **Request changes outside IDLE:** `data_we`, address or data changing while not in IDLE have no effect, because the latched copy is used.
- **`data_byteenable` = 0000:** forwarded unchanged; the transaction still occurs and completes.

## Timing
- **Reset (async, `reset`=0):**
  - State = IDLE; `last_grant` = DATA, so fetch wins the first tie.
  - All outputs are 0, including both rdata hold registers, `busy` and both `*_done`.
  - Reset takes effect immediately, even mid-ISSUE. Any in-flight transaction is abandoned with no `*_done`.
- **Minimum latency:** request seen in IDLE at cycle 0 → ISSUE at cycle 1 → RESP (`done`) at cycle 2, provided `waitrequest`=0 at cycle 1.
- **Stalls:** each cycle of `waitrequest`=1 in ISSUE adds one cycle of latency.
- **Back-to-back throughput:** minimum 3 cycles per transaction (IDLE, ISSUE, RESP).
- **Losing requester:** waits through the winner's full transaction and is granted in the following IDLE. Worst case is one transaction plus one IDLE cycle.
- `read` and `write` are never both 1; at most one `*_done` is high per cycle.
- `waitrequest` is ignored outside ISSUE.

## Test plan
- **Single fetch:** `fetch_req`=1, `fetch_addr`=BFC00000, `waitrequest`=0, `readdata`=2402000A in the RESP cycle → `read`=1 with `address`=BFC00000 at cycle 1; `fetch_done`=1 with `fetch_rdata`=2402000A at cycle 2; `fetch_rdata` still 2402000A at cycle 5.
- **Stalled store:** `data_req`=1, `data_we`=1, `data_addr`=00001007, `data_wdata`=DEADBEEF, `data_byteenable`=0011, `waitrequest`=1 for 3 cycles → `write` held 4 cycles with `address`=00001004, `writedata`=DEADBEEF, `byteenable`=0011; `data_done` pulses once at cycle 5; `data_rdata` unchanged.
- **Simultaneous requests after reset:** both requests high, held through two transactions → fetch granted first, then data; `fetch_done` at cycle 2, `data_done` at cycle 5.
- **Round-robin:** both requests continuously reasserted for 4 transactions → grant order fetch, data, fetch, data.
- **Reset mid-ISSUE:** `reset`=0 asynchronously during a stalled read → `read` and `busy` drop immediately; no `done`; after release, fetch wins a tie.
- **Load of 0000FFFF with `data_byteenable`=1100:** → `byteenable`=1100, `data_rdata`=0000FFFF with `data_done`; `fetch_rdata` unaffected.
